// File: rtl/inst_memory.sv
// inst_memory: parametrised instruction memory with a valid/ready fetch port,
// a held one-entry response register, pipeline flush and a program-load
// write port. Optional misaligned-fetch fault: define IMEM_MISALIGN_CHECK_EN.
module inst_memory #(
    parameter int ILEN   = 32,
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [ADDR_W-1:0]        req_addr,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ILEN-1:0]          rsp_instr,
    output logic                     rsp_err,
    input  logic                     flush,
    input  logic                     prog_we,
    input  logic [$clog2(DEPTH)-1:0] prog_addr,
    input  logic [ILEN-1:0]          prog_data
);

    localparam int IDX_W = $clog2(DEPTH);
    // One extra bit so DEPTH*4 never wraps when ADDR_W is tight.
    localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH) << 2;
    localparam logic [31:0]     NOP32 = 32'h0000_0013;

    typedef enum logic {EMPTY, HOLD} state_t;

    state_t             state, state_nxt;
    logic [ILEN-1:0]    mem [DEPTH] = '{default: '0};
    logic [IDX_W-1:0]   idx;
    logic               out_of_range;
    logic               fault;
    logic               accept;

    assign idx          = req_addr[IDX_W+1:2];
    // Full-width unsigned compare: any upper address bit set is a fault.
    assign out_of_range = {1'b0, req_addr} >= LIMIT;
`ifdef IMEM_MISALIGN_CHECK_EN
    assign fault        = out_of_range || (req_addr[1:0] != 2'b00);
`else
    assign fault        = out_of_range;
`endif

    assign rsp_valid = (state == HOLD);
    assign req_ready = !flush && (!rsp_valid || rsp_ready);
    assign accept    = req_valid && req_ready;

    // Response state register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= EMPTY;
        else        state <= state_nxt;
    end

    // Next state: flush wins, then a new fetch, then a consumed response drains.
    always_comb begin
        state_nxt = state;
        if (flush)                          state_nxt = EMPTY;
        else if (accept)                    state_nxt = HOLD;
        else if (state == HOLD && rsp_ready) state_nxt = EMPTY;
    end

    // Response data: loaded only on acceptance, otherwise held (even once drained).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_instr <= '0;
            rsp_err   <= 1'b0;
        end else if (accept) begin
            if (fault) begin
                rsp_instr <= ILEN'(NOP32);
                rsp_err   <= 1'b1;
            end else begin
                rsp_instr <= mem[idx];
                rsp_err   <= 1'b0;
            end
        end
    end

    // Program load; independent of reset so a loader can run while the core is held.
    // Same-edge read above sees the old word.
    always_ff @(posedge clk) begin
        if (prog_we) mem[prog_addr] <= prog_data;
    end

endmodule

// File: tb/tb_inst_memory.sv
// tb_inst_memory: table-driven fetch vectors plus directed sequences for
// backpressure, flush, mid-run reset and same-word write/read collision.
module tb_inst_memory;

    localparam int ILEN = 32, DEPTH = 256, ADDR_W = 32;

    logic              clk = 0;
    logic              rst_n, req_valid, req_ready, rsp_valid, rsp_ready;
    logic              rsp_err, flush, prog_we;
    logic [ADDR_W-1:0] req_addr;
    logic [ILEN-1:0]   rsp_instr, prog_data;
    logic [7:0]        prog_addr;

    int total = 0;
    int bad   = 0;

    inst_memory #(.ILEN(ILEN), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_instr(rsp_instr), .rsp_err(rsp_err),
        .flush(flush), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data)
    );

    always #5 clk = ~clk;

    localparam logic [31:0] W0 = 32'h0050_0093, W1 = 32'h00A0_0113;
    localparam logic [31:0] W2 = 32'h0020_81B3, W3 = 32'h0030_2023;
    localparam logic [31:0] W5 = 32'h0010_0093, W255 = 32'hFFFF_F06F;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
        logic        err;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    // Advance one clock; land 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic prog(input logic [7:0] a, input logic [31:0] d);
        prog_we = 1; prog_addr = a; prog_data = d;
        step();
        prog_we = 0;
    endtask

    initial begin
        vecs[0] = '{32'h0000_0000, W0,   1'b0};
        vecs[1] = '{32'h0000_0004, W1,   1'b0};
        vecs[2] = '{32'h0000_0008, W2,   1'b0};
        vecs[3] = '{32'h0000_000C, W3,   1'b0};
        vecs[4] = '{32'h0000_03FC, W255, 1'b0};
        vecs[5] = '{32'h0000_0400, NOP,  1'b1};
        vecs[6] = '{32'hFFFF_FFFC, NOP,  1'b1};
`ifdef IMEM_MISALIGN_CHECK_EN
        vecs[7] = '{32'h0000_0006, NOP,  1'b1};
        vecs[9] = '{32'h0000_03FF, NOP,  1'b1};
`else
        vecs[7] = '{32'h0000_0006, W1,   1'b0};
        vecs[9] = '{32'h0000_03FF, W255, 1'b0};
`endif
        vecs[8] = '{32'h0000_0010, 32'h0, 1'b0};  // never written: initial zero

        rst_n = 0; req_valid = 0; req_addr = '0; rsp_ready = 0; flush = 0;
        prog_we = 0; prog_addr = '0; prog_data = '0;
        step(); step();
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_instr", rsp_instr, 32'd0);
        chk("rst_err",   32'(rsp_err), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd1);

        // Loads proceed while reset is held.
        prog(8'd0, W0); prog(8'd1, W1); prog(8'd2, W2);
        rst_n = 1;
        prog(8'd3, W3); prog(8'd5, W5); prog(8'd255, W255);

        // Back-to-back fetches, one per cycle.
        rsp_ready = 1;
        for (int i = 0; i < 10; i++) begin
            req_valid = 1; req_addr = vecs[i].addr;
            #1;
            chk($sformatf("v%0d_ready", i), 32'(req_ready), 32'd1);
            step();
            chk($sformatf("v%0d_valid", i), 32'(rsp_valid), 32'd1);
            chk($sformatf("v%0d_instr", i), rsp_instr, vecs[i].instr);
            chk($sformatf("v%0d_err", i), 32'(rsp_err), 32'(vecs[i].err));
        end
        req_valid = 0;
        step();
        chk("drain_valid", 32'(rsp_valid), 32'd0);
        chk("drain_keep",  rsp_instr, vecs[9].instr);

        // Backpressure: hold word 1 for 3 cycles; a write to word 1 must not disturb it.
        req_valid = 1; req_addr = 32'h4;
        step();
        rsp_ready = 0; req_addr = 32'h8;
        for (int i = 0; i < 3; i++) begin
            prog_we = (i == 1); prog_addr = 8'd1; prog_data = 32'h1111_1111;
            #1;
            chk($sformatf("bp%0d_ready", i), 32'(req_ready), 32'd0);
            step();
            chk($sformatf("bp%0d_valid", i), 32'(rsp_valid), 32'd1);
            chk($sformatf("bp%0d_instr", i), rsp_instr, W1);
        end
        prog_we = 0;
        rsp_ready = 1;
        #1;
        chk("bp_release_ready", 32'(req_ready), 32'd1);
        step();
        chk("bp_release_instr", rsp_instr, W2);
        chk("bp_release_valid", 32'(rsp_valid), 32'd1);

        // Flush while holding: response dropped, offered request ignored.
        rsp_ready = 0; flush = 1; req_addr = 32'hC;
        #1;
        chk("fl_ready", 32'(req_ready), 32'd0);
        step();
        flush = 0; req_valid = 0;
        chk("fl_valid", 32'(rsp_valid), 32'd0);
        chk("fl_noaccept", rsp_instr, W2);

        // Reset mid-run while holding.
        req_valid = 1; req_addr = 32'hC;
        step();
        req_valid = 0;
        chk("pre_rst_instr", rsp_instr, W3);
        rst_n = 0;
        step();
        chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_instr", rsp_instr, 32'd0);
        chk("mid_rst_err",   32'(rsp_err), 32'd0);
        rst_n = 1; rsp_ready = 1;
        req_valid = 1; req_addr = 32'h0;
        step();
        chk("post_rst_w0", rsp_instr, W0);
        req_addr = 32'hC;
        step();
        chk("post_rst_w3", rsp_instr, W3);

        // Same-word write and fetch: old word, then new.
        req_addr = 32'h14; prog_we = 1; prog_addr = 8'd5; prog_data = 32'hDEAD_BEEF;
        step();
        prog_we = 0;
        chk("coll_old", rsp_instr, W5);
        step();
        chk("coll_new", rsp_instr, 32'hDEAD_BEEF);
        chk("coll_err", 32'(rsp_err), 32'd0);
        req_valid = 0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
